// File: rtl/spi_ram_pkg.sv
// Shared constants, FSM states and frame packing for the SPI RAM initiator.
// Frame: {read, 3'b000, adrs[3:0], data[7:0]}, sent MSB first.
package spi_ram_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 8;
   localparam int RW_BIT  = 15;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   // Read frames carry a zero data byte; the responder owns those bit times.
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic              rd,
      input logic [ADDR_W-1:0] a,
      input logic [DATA_W-1:0] d
   );
      logic [DATA_W-1:0] payload;
      payload = rd ? '0 : d;
      return {rd, 3'b000, a, payload};
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock and phase timer: one half-period counter shared by all states.
// Strobes are combinational and mark the clk edge on which the action lands.
module spi_clk_gen
   import spi_ram_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic run,
   output logic sclk,
   output logic rise,
   output logic fall,
   output logic phase_end
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign phase_end = en && (cnt == '0);
   assign rise      = phase_end && run && !sclk;
   assign fall      = phase_end && sclk;

   // Count down each half period; reload on every phase change or while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= RELOAD;
         sclk <= 1'b0;
      end else begin
         if (!en || phase_end) begin
            cnt <= RELOAD;
         end else begin
            cnt <= cnt - CW'(1);
         end
         if (rise) begin
            sclk <= 1'b1;
         end else if (fall) begin
            sclk <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/spi_ram_master.sv
// SPI mode-0 initiator issuing single-byte reads/writes to a 16x8 RAM.
// Outputs are registered; FSM next values come from one combinational block.
module spi_ram_master
   import spi_ram_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       read,
   input  logic [3:0] adrs,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       busy,
   output logic       done,
   output logic       sclk,
   output logic       cs_n,
   output logic       mosi,
   input  logic       miso
);

   state_t state, state_nxt;

   logic [FRAME_W-1:0] tx;
   logic [DATA_W-1:0]  rx;
   logic [3:0]         bit_cnt;
   logic               rd_q;

   logic cs_n_nxt, busy_nxt, done_nxt, mosi_nxt;
   logic load, load_rd, en, run;
   logic rise, fall, phase_end;

   logic [FRAME_W-1:0] frame;
   assign frame = build_frame(read, adrs, data_in);

   spi_clk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_clk (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .run      (run),
      .sclk     (sclk),
      .rise     (rise),
      .fall     (fall),
      .phase_end(phase_end)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and next output values; bit_cnt==0 after the 16th fall stops sclk.
   always_comb begin
      state_nxt = state;
      cs_n_nxt  = cs_n;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      mosi_nxt  = mosi;
      load      = 1'b0;
      load_rd   = 1'b0;
      en        = (state != IDLE);
      run       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SETUP;
               cs_n_nxt  = 1'b0;
               busy_nxt  = 1'b1;
               mosi_nxt  = frame[RW_BIT];
               load      = 1'b1;
            end
         end
         SETUP: begin
            run = 1'b1;
            if (phase_end) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            run = (bit_cnt != 4'd0);
            if (fall) begin
               mosi_nxt = tx[FRAME_W-2];
            end
            if (phase_end && !sclk && bit_cnt == 4'd0) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (phase_end) begin
               state_nxt = GAP;
               cs_n_nxt  = 1'b1;
               mosi_nxt  = 1'b0;
            end
         end
         GAP: begin
            if (phase_end) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               load_rd   = rd_q;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered bus and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_n <= 1'b1;
         busy <= 1'b0;
         done <= 1'b0;
         mosi <= 1'b0;
      end else begin
         cs_n <= cs_n_nxt;
         busy <= busy_nxt;
         done <= done_nxt;
         mosi <= mosi_nxt;
      end
   end

   // TX/RX shift registers, bit counter and read result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx       <= '0;
         rx       <= '0;
         bit_cnt  <= 4'd0;
         rd_q     <= 1'b0;
         data_out <= '0;
      end else begin
         if (load) begin
            tx      <= frame;
            rd_q    <= read;
            bit_cnt <= 4'd0;
         end else if (fall && state == SHIFT) begin
            tx      <= {tx[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
         end
         if (rise) begin
            rx <= {rx[DATA_W-2:0], miso};
         end
         if (load_rd) begin
            data_out <= rx;
         end
      end
   end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two instances (CLK_DIV=4 and 1) on a shared clk,
// each talking to a behavioural SPI RAM responder.
module tb_spi_ram_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      rst_v, start_v, read_v;
   logic [1:0][3:0] adrs_v;
   logic [1:0][7:0] data_in_v;
   logic [1:0][7:0] data_out_w;
   logic [1:0]      busy_w, done_w, sclk_w, cs_n_w, mosi_w, miso_w;

   int checks = 0;
   int failures = 0;

   spi_ram_master #(.CLK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .read(read_v[0]),
      .adrs(adrs_v[0]), .data_in(data_in_v[0]), .data_out(data_out_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .sclk(sclk_w[0]),
      .cs_n(cs_n_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0])
   );

   spi_ram_master #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .read(read_v[1]),
      .adrs(adrs_v[1]), .data_in(data_in_v[1]), .data_out(data_out_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .sclk(sclk_w[1]),
      .cs_n(cs_n_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1])
   );

   // Responder model state.
   bit   [7:0]  rmem [2][16];
   logic [15:0] rf [2];
   logic [7:0]  hdr [2];
   logic [15:0] last_frame [2];
   int          n [2];
   int          fcount [2];
   int          dropped [2];
   int          force_m [2];
   logic [1:0]  pcs = 2'b11;
   logic [1:0]  psclk = 2'b00;
   logic [7:0]  rb;

   // Bench expectations.
   logic [7:0] shadow [2][16];
   logic [7:0] exp_dout [2];

   // SPI RAM responder: sample mosi on sclk rise, drive miso on sclk fall.
   always @(cs_n_w, sclk_w) begin
      for (int g = 0; g < 2; g++) begin
         if (pcs[g] && !cs_n_w[g]) begin
            n[g] = 0;
            rf[g] = '0;
            hdr[g] = '0;
            miso_w[g] = (force_m[g] == 1);
         end else if (!pcs[g] && cs_n_w[g]) begin
            if (n[g] == 16) begin
               fcount[g]++;
               last_frame[g] = rf[g];
               if (!rf[g][15]) rmem[g][rf[g][11:8]] = rf[g][7:0];
            end else begin
               dropped[g]++;
            end
            n[g] = 0;
            miso_w[g] = 1'b0;
         end else if (!cs_n_w[g] && !psclk[g] && sclk_w[g]) begin
            rf[g] = {rf[g][14:0], mosi_w[g]};
            n[g]++;
            if (n[g] == 8) hdr[g] = rf[g][7:0];
         end else if (!cs_n_w[g] && psclk[g] && !sclk_w[g]) begin
            if (force_m[g] >= 0) begin
               miso_w[g] = (force_m[g] == 1);
            end else if (n[g] >= 8 && n[g] < 16 && hdr[g][7]) begin
               rb = rmem[g][hdr[g][3:0]];
               miso_w[g] = rb[15 - n[g]];
            end else begin
               miso_w[g] = 1'b0;
            end
         end
         pcs[g] = cs_n_w[g];
         psclk[g] = sclk_w[g];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transaction on instance g with full timing and frame checks.
   task automatic run_txn(input int g, input bit rd, input logic [3:0] a,
                          input logic [7:0] d, input int poke);
      int D, t, nr, nf, bad, first_rise, cs_t, done_t, nd, fc0;
      logic ps;
      logic [15:0] exp_frame;
      D = (g == 0) ? 4 : 1;
      exp_frame = {rd, 3'b000, a, rd ? 8'h00 : d};
      if (rd) begin
         if (force_m[g] == 1) exp_dout[g] = 8'hFF;
         else if (force_m[g] == 0) exp_dout[g] = 8'h00;
         else exp_dout[g] = shadow[g][a];
      end else begin
         shadow[g][a] = d;
      end
      fc0 = fcount[g];
      @(negedge clk);
      start_v[g] = 1'b1;
      read_v[g] = rd;
      adrs_v[g] = a;
      data_in_v[g] = d;
      @(posedge clk);
      #1;
      start_v[g] = 1'b0;
      chk("cs_fall", cs_n_w[g], 0);
      chk("busy_rise", busy_w[g], 1);
      chk("mosi_b15", mosi_w[g], exp_frame[15]);
      nr = 0; nf = 0; bad = 0; nd = 0;
      first_rise = -1; cs_t = -1; done_t = -1;
      ps = sclk_w[g];
      for (t = 1; t <= 37 * D + 4; t++) begin
         @(posedge clk);
         #1;
         if (poke > 0 && t == poke) start_v[g] = 1'b1;
         if (poke > 0 && t == poke + 1) start_v[g] = 1'b0;
         if (!ps && sclk_w[g]) begin
            if (first_rise < 0) first_rise = t;
            if (t != D + 2 * D * nr) bad++;
            nr++;
         end
         if (ps && !sclk_w[g]) nf++;
         ps = sclk_w[g];
         if (cs_n_w[g] && cs_t < 0) cs_t = t;
         if (done_w[g]) begin
            nd++;
            done_t = t;
            chk("busy_at_done", busy_w[g], 0);
            chk("dout_at_done", data_out_w[g], exp_dout[g]);
         end
      end
      chk("first_rise", first_rise, D);
      chk("sclk_rises", nr, 16);
      chk("sclk_falls", nf, 16);
      chk("sclk_period_err", bad, 0);
      chk("cs_rise_t", cs_t, 34 * D);
      chk("done_t", done_t, 35 * D);
      chk("done_count", nd, 1);
      chk("frame_count", fcount[g], fc0 + 1);
      chk("frame", last_frame[g], exp_frame);
      chk("dout_after", data_out_w[g], exp_dout[g]);
   endtask

   initial begin
      int fc0, dr0, f0, f1, r0, d0, d1, c;
      logic pc;
      logic [3:0] a1, a2;
      logic [7:0] d2, exp_rd;
      int cf[$], cr[$], dt[$];

      force_m[0] = -1;
      force_m[1] = -1;
      for (int g = 0; g < 2; g++) begin
         exp_dout[g] = 8'h00;
         for (int i = 0; i < 16; i++) shadow[g][i] = 8'h00;
      end
      rst_v = 2'b00;
      start_v = '0;
      read_v = '0;
      adrs_v = '0;
      data_in_v = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("rst_cs_n", cs_n_w[g], 1);
         chk("rst_sclk", sclk_w[g], 0);
         chk("rst_mosi", mosi_w[g], 0);
         chk("rst_busy", busy_w[g], 0);
         chk("rst_done", done_w[g], 0);
         chk("rst_dout", data_out_w[g], 0);
      end
      @(negedge clk);
      rst_v = 2'b11;

      run_txn(0, 1'b0, 4'd2, 8'd45, 0);
      chk("frame_022d", last_frame[0], 16'h022D);
      run_txn(0, 1'b1, 4'd2, 8'h00, 0);
      chk("read_2d", data_out_w[0], 8'h2D);
      run_txn(0, 1'b0, 4'd7, 8'($urandom), 50);
      run_txn(0, 1'b0, 4'd5, 8'hA5, 0);

      fc0 = fcount[0];
      dr0 = dropped[0];
      @(negedge clk);
      start_v[0] = 1'b1;
      read_v[0] = 1'b0;
      adrs_v[0] = 4'd9;
      data_in_v[0] = 8'h77;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (60) @(posedge clk);
      #2;
      chk("pre_rst_sclk", sclk_w[0], 1);
      rst_v[0] = 1'b0;
      #1;
      exp_dout[0] = 8'h00;
      chk("mid_rst_cs_n", cs_n_w[0], 1);
      chk("mid_rst_sclk", sclk_w[0], 0);
      chk("mid_rst_busy", busy_w[0], 0);
      chk("mid_rst_mosi", mosi_w[0], 0);
      chk("mid_rst_dout", data_out_w[0], 0);
      @(negedge clk);
      rst_v[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_cs_idle", cs_n_w[0], 1);
      chk("rst_frames", fcount[0], fc0);
      chk("rst_dropped", dropped[0], dr0 + 1);
      run_txn(0, 1'b1, 4'd5, 8'h3C, 0);
      chk("read_a5", data_out_w[0], 8'hA5);

      repeat (4) run_txn(0, 1'($urandom), 4'($urandom), 8'($urandom), 0);
      repeat (8) run_txn(1, 1'($urandom), 4'($urandom), 8'($urandom), 0);

      force_m[1] = 1;
      run_txn(1, 1'b1, 4'($urandom), 8'($urandom), 0);
      chk("miso_ones", data_out_w[1], 8'hFF);
      force_m[1] = 0;
      run_txn(1, 1'b1, 4'($urandom), 8'($urandom), 0);
      chk("miso_zeros", data_out_w[1], 8'h00);
      force_m[1] = -1;

      a1 = 4'($urandom);
      a2 = 4'($urandom);
      d2 = 8'($urandom);
      exp_rd = shadow[1][a1];
      fc0 = fcount[1];
      @(negedge clk);
      start_v[1] = 1'b1;
      read_v[1] = 1'b1;
      adrs_v[1] = a1;
      data_in_v[1] = 8'($urandom);
      pc = 1'b1;
      for (c = 0; c < 90; c++) begin
         @(posedge clk);
         #1;
         if (pc && !cs_n_w[1]) begin
            cf.push_back(c);
            if (cf.size() == 2) start_v[1] = 1'b0;
         end
         if (!pc && cs_n_w[1]) cr.push_back(c);
         pc = cs_n_w[1];
         if (done_w[1]) begin
            dt.push_back(c);
            if (dt.size() == 1) begin
               chk("b2b_read", data_out_w[1], exp_rd);
               read_v[1] = 1'b0;
               adrs_v[1] = a2;
               data_in_v[1] = d2;
            end
         end
      end
      start_v[1] = 1'b0;
      shadow[1][a2] = d2;
      f0 = (cf.size() > 0) ? cf[0] : -1000;
      f1 = (cf.size() > 1) ? cf[1] : -1000;
      r0 = (cr.size() > 0) ? cr[0] : -1000;
      d0 = (dt.size() > 0) ? dt[0] : -1000;
      d1 = (dt.size() > 1) ? dt[1] : -1000;
      chk("b2b_frames_seen", cf.size(), 2);
      chk("b2b_dones", dt.size(), 2);
      chk("b2b_done1_t", d0 - f0, 35);
      chk("b2b_cs_gap_ok", (f1 - r0) >= 1, 1);
      chk("b2b_done2_t", d1 - f1, 35);
      chk("b2b_fcount", fcount[1], fc0 + 2);
      chk("b2b_wr_frame", last_frame[1], {4'b0000, a2, d2});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
